case_2_sdiv_5s_4s_5_seq: RTL and testbench

Sequential signed integer divider, the inverse operator to the team's `case_2_mul_5s_4s_5` combinational signed multiplier. It sits in the same HLS operator library. It takes a signed `din0_WIDTH` dividend and a signed `din1_WIDTH` divisor and produces a signed quotient truncated to `dout_WIDTH` bits, plus a remainder. It uses an iterative restoring algorithm, one quotient bit per enabled clock, behind a start/done handshake.

---
 rtl/case_2_sdiv_5s_4s_5_seq.sv | 107 ++++++++++
 tb/tb_case_2_sdiv_5s_4s_5_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/case_2_sdiv_5s_4s_5_seq.sv
// Sequential signed restoring divider, one quotient bit per enabled clock.
// C-style semantics: quotient truncates toward zero, remainder follows the dividend.
module case_2_sdiv_5s_4s_5_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 5,
  parameter int din1_WIDTH = 4,
  parameter int dout_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero
);

  localparam int unused_id = ID;
  localparam int CW = $clog2(din0_WIDTH + 1);
  localparam int RW = din1_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t                state;
  logic [din0_WIDTH-1:0] a;
  logic [din0_WIDTH-1:0] q;
  logic [din1_WIDTH-1:0] b;
  logic [din1_WIDTH-1:0] r;
  logic [CW-1:0]         cnt;
  logic                  sq;
  logic                  sr;

  logic [RW-1:0]         shifted;
  logic                  ge;
  logic [din1_WIDTH-1:0] diff;
  logic [din0_WIDTH-1:0] qs;
  logic [din1_WIDTH-1:0] rs;

  assign shifted = {r, a[din0_WIDTH-1]};
  assign ge      = shifted >= {1'b0, b};
  // Only used when ge holds, so the true difference fits in din1_WIDTH bits.
  assign diff    = shifted[din1_WIDTH-1:0] - b;
  assign qs      = sq ? -q : q;
  assign rs      = sr ? -r : r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      a           <= '0;
      q           <= '0;
      b           <= '0;
      r           <= '0;
      cnt         <= '0;
      sq          <= 1'b0;
      sr          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dout        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else if (ce) begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sq    <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
            sr    <= din0[din0_WIDTH-1];
            a     <= din0[din0_WIDTH-1] ? -din0 : din0;
            b     <= din1[din1_WIDTH-1] ? -din1 : din1;
            r     <= '0;
            q     <= '0;
            cnt   <= CW'(din0_WIDTH);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          a   <= a << 1;
          q   <= {q[din0_WIDTH-2:0], ge};
          r   <= ge ? diff : shifted[din1_WIDTH-1:0];
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= SIGN;
        end
        SIGN: begin
          if (b == '0) begin
            dout        <= '1;
            rem         <= '0;
            div_by_zero <= 1'b1;
          end else begin
            dout        <= dout_WIDTH'(signed'(qs));
            rem         <= rs;
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_case_2_sdiv_5s_4s_5_seq.sv
// Self-checking bench for case_2_sdiv_5s_4s_5_seq.
// Vector table plus scoreboard queue; hand sequences for handshake, ce and reset.
module tb_case_2_sdiv_5s_4s_5_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic       start;
  logic [4:0] din0;
  logic [3:0] din1;
  logic       busy;
  logic       done;
  logic [4:0] dout;
  logic [3:0] rem;
  logic       div_by_zero;

  case_2_sdiv_5s_4s_5_seq #(
    .ID(1), .din0_WIDTH(5), .din1_WIDTH(4), .dout_WIDTH(5)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start),
    .din0(din0), .din1(din1), .busy(busy), .done(done),
    .dout(dout), .rem(rem), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
  } vec_t;

  typedef struct {
    int q;
    int r;
    int z;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   issue_k = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int lat);
    exp_t e;
    e.lat = lat;
    if (b == 0) begin
      e.q = -1; e.r = 0; e.z = 1;
    end else begin
      e.q = a / b;
      if (e.q == 16) e.q = -16;
      e.r = a % b;
      e.z = 0;
    end
    return e;
  endfunction

  task automatic issue(input int a, input int b);
    din0    = a[4:0];
    din1    = b[3:0];
    start   = 1'b1;
    issue_k = cyc + 1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int   n = 0;
    exp_t e;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL %s timeout: got no done expected done", name);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL %s: got done expected empty scoreboard", name);
      return;
    end
    e = sb.pop_front();
    chk({name, " dout"}, int'($signed(dout)), e.q);
    chk({name, " rem"}, int'($signed(rem)), e.r);
    chk({name, " dbz"}, int'(div_by_zero), e.z);
    chk({name, " latency"}, cyc - issue_k, e.lat);
  endtask

  vec_t tbl[9];
  int   prev_k;
  int   ndone;
  int   ra, rb;

  initial begin
    tbl[0] = '{13, 3, 4, 1, 0};
    tbl[1] = '{-13, 3, -4, -1, 0};
    tbl[2] = '{13, -3, -4, 1, 0};
    tbl[3] = '{-13, -3, 4, -1, 0};
    tbl[4] = '{-16, -1, -16, 0, 0};
    tbl[5] = '{15, -8, -1, 7, 0};
    tbl[6] = '{0, 5, 0, 0, 0};
    tbl[7] = '{7, 0, -1, 0, 1};
    tbl[8] = '{6, 2, 3, 0, 0};

    reset = 1'b1; ce = 1'b1; start = 1'b0; din0 = '0; din1 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset dout", int'(dout), 0);
    chk("reset rem", int'(rem), 0);
    chk("reset dbz", int'(div_by_zero), 0);

    // Table, issued back-to-back on done cycles.
    prev_k = 0;
    for (int i = 0; i < 9; i++) begin
      sb.push_back('{tbl[i].q, tbl[i].r, tbl[i].z, 6});
      issue(tbl[i].a, tbl[i].b);
      if (i > 0) chk($sformatf("interval %0d", i), issue_k - prev_k, 7);
      prev_k = issue_k;
      chk($sformatf("busy after start %0d", i), int'(busy), 1);
      wait_done($sformatf("vec %0d", i));
    end

    for (int i = 0; i < 10; i++) begin
      ra = int'($urandom_range(0, 31)) - 16;
      rb = int'($urandom_range(0, 15)) - 8;
      sb.push_back(model(ra, rb, 6));
      issue(ra, rb);
      wait_done($sformatf("rand %0d/%0d", ra, rb));
    end

    // Start while busy must be ignored.
    @(negedge clk);
    sb.push_back('{2, 3, 0, 6});
    issue(11, 4);
    din0 = 5'd3; din1 = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy ignore");
    @(negedge clk);
    chk("done pulse width", int'(done), 0);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no extra done", ndone, 0);

    // Clock enable stall mid-CALC plus done stretch.
    sb.push_back('{4, 1, 0, 9});
    issue(13, 3);
    @(negedge clk);
    ce = 1'b0;
    repeat (3) @(negedge clk);
    ce = 1'b1;
    wait_done("ce stall");
    ce = 1'b0;
    repeat (3) @(negedge clk);
    chk("done held ce low", int'(done), 1);
    ce = 1'b1;
    @(negedge clk);
    chk("done cleared", int'(done), 0);

    // Asynchronous reset in the 3rd CALC cycle.
    issue(12, 5);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst dout", int'(dout), 0);
    chk("rst rem", int'(rem), 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no done after reset", ndone, 0);
    sb.push_back('{4, 1, 0, 6});
    issue(9, 2);
    wait_done("after reset");

    chk("scoreboard empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
